// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI mode-0 slave register bank feeding the RSA operands and start/stop commands
// SPI_READBACK_EN: when defined, P/E/M/CONST/SPARE read back their contents; otherwise they read as 0.
module spi_reg_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             spi_cs_n,
  input  logic             spi_clk,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             start_cmd,
  output logic             stop_cmd,
  output logic [WIDTH-1:0] rsa_p,
  output logic [WIDTH-1:0] rsa_e,
  output logic [WIDTH-1:0] rsa_m,
  output logic [WIDTH-1:0] rsa_const,
  output logic [WIDTH-1:0] spare,
  input  logic [WIDTH-1:0] rsa_c,
  input  logic             irq
);

  localparam int FRAME = 8 + WIDTH;
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0] FRAME_FULL = CW'(FRAME);
  localparam logic [CW-1:0] CMD_LAST   = CW'(7);
  localparam logic [CW-1:0] CMD_BITS   = CW'(8);

  logic [1:0]       cs_sync, sclk_sync, mosi_sync;
  logic             sclk_d;
  logic             cs_s, sclk_rise, sclk_fall;
  logic [CW-1:0]    bit_cnt;
  logic [FRAME-1:0] rx_sr;
  logic [WIDTH-1:0] tx_sr;
  logic             commit;
  logic [2:0]       rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [2:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  assign cs_s      = cs_sync[1];
  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  // Address is complete on the 8th rising edge: two bits already shifted, the last still on mosi.
  assign rd_addr   = {rx_sr[1:0], mosi_sync[1]};
  assign wr_addr   = rx_sr[WIDTH+2:WIDTH];
  assign wr_data   = rx_sr[WIDTH-1:0];

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      3'd0: rd_data[0] = irq;
      3'd5: rd_data = rsa_c;
      3'd7: rd_data = WIDTH'(8'hA5);
`ifdef SPI_READBACK_EN
      3'd1: rd_data = rsa_p;
      3'd2: rd_data = rsa_e;
      3'd3: rd_data = rsa_m;
      3'd4: rd_data = rsa_const;
      3'd6: rd_data = spare;
`endif
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      commit    <= 1'b0;
      spi_miso  <= 1'b0;
      start_cmd <= 1'b0;
      stop_cmd  <= 1'b0;
      rsa_p     <= '0;
      rsa_e     <= '0;
      rsa_m     <= '0;
      rsa_const <= '0;
      spare     <= '0;
    end else begin
      cs_sync   <= {cs_sync[0], spi_cs_n};
      sclk_sync <= {sclk_sync[0], spi_clk};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sclk_d    <= sclk_sync[1];
      start_cmd <= 1'b0;
      stop_cmd  <= 1'b0;
      commit    <= 1'b0;

      if (commit && ena) begin
        case (wr_addr)
          3'd0: begin
            // Stop wins over start when both bits are set.
            if (wr_data[1]) stop_cmd <= 1'b1;
            else if (wr_data[0]) start_cmd <= 1'b1;
          end
          3'd1: rsa_p     <= wr_data;
          3'd2: rsa_e     <= wr_data;
          3'd3: rsa_m     <= wr_data;
          3'd4: rsa_const <= wr_data;
          3'd6: spare     <= wr_data;
          default: ;
        endcase
      end

      if (!ena || cs_s) begin
        bit_cnt  <= '0;
        rx_sr    <= '0;
        tx_sr    <= '0;
        spi_miso <= 1'b0;
        commit   <= 1'b0;
      end else begin
        if (sclk_rise && bit_cnt < FRAME_FULL) begin
          bit_cnt <= bit_cnt + 1'b1;
          rx_sr   <= {rx_sr[FRAME-2:0], mosi_sync[1]};
          if (bit_cnt == CMD_LAST) tx_sr <= rx_sr[6] ? '0 : rd_data;
          if (bit_cnt == FRAME_LAST) commit <= rx_sr[FRAME-2];
        end
        // MISO is a register fed on falling edges so the master sees bit WIDTH-1 at the 9th rising edge.
        if (sclk_fall && bit_cnt >= CMD_BITS) begin
          spi_miso <= tx_sr[WIDTH-1];
          tx_sr    <= {tx_sr[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - self-checking bench for spi_reg_bank (table vectors, corner sequences, random frames)
module tb_spi_reg_bank;

  localparam int WIDTH = 8;
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, ena, spi_cs_n, spi_clk, spi_mosi, spi_miso;
  logic start_cmd, stop_cmd, irq;
  logic [WIDTH-1:0] rsa_p, rsa_e, rsa_m, rsa_const, spare, rsa_c;

  int checks = 0;
  int failures = 0;
  int start_seen = 0;
  int stop_seen = 0;
  logic [7:0] snap3, snap4;
  logic [7:0] mdl [0:7];

  always #5 clk = ~clk;

  spi_reg_bank #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .start_cmd(start_cmd), .stop_cmd(stop_cmd),
    .rsa_p(rsa_p), .rsa_e(rsa_e), .rsa_m(rsa_m), .rsa_const(rsa_const), .spare(spare),
    .rsa_c(rsa_c), .irq(irq)
  );

  always @(negedge clk) begin
    if (start_cmd) start_seen++;
    if (stop_cmd) stop_seen++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {7'b0, irq};
      3'd5: return rsa_c;
      3'd7: return 8'hA5;
      default: return RB ? mdl[a] : 8'h00;
    endcase
  endfunction

  task automatic model_write(input logic [2:0] a, input logic [7:0] d);
    if (a != 3'd0 && a != 3'd5 && a != 3'd7) mdl[a] = d;
  endtask

  task automatic chk_regs(input string tag);
    check({tag, " rsa_p"}, rsa_p, mdl[1]);
    check({tag, " rsa_e"}, rsa_e, mdl[2]);
    check({tag, " rsa_m"}, rsa_m, mdl[3]);
    check({tag, " rsa_const"}, rsa_const, mdl[4]);
    check({tag, " spare"}, spare, mdl[6]);
  endtask

  // Mode-0 master: 6-clk low and high phases; MISO sampled just before each data-phase rising edge.
  task automatic spi_xfer(input logic [15:0] frame, input int nbits, input bit hold, output logic [7:0] rx);
    rx = '0;
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = frame[15-i];
      repeat (6) @(negedge clk);
      if (i >= 8) rx = {rx[6:0], spi_miso};
      spi_clk = 1'b1;
      if (i == nbits - 1) begin
        repeat (3) @(negedge clk);
        snap3 = rsa_p;
        @(negedge clk);
        snap4 = rsa_p;
        repeat (2) @(negedge clk);
      end else begin
        repeat (6) @(negedge clk);
      end
      spi_clk = 1'b0;
    end
    repeat (6) @(negedge clk);
    if (!hold) begin
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] c_in;
    logic       irq_in;
    logic       is_rd;
    logic [7:0] exp_rd;
    int         exp_start;
    int         exp_stop;
  } vec_t;

  vec_t vt [13];

  initial begin
    logic [7:0] rx, cmd, data;
    int s0, t0, nb, es, et;

    vt[0]  = '{8'h83, 8'hC4, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0};
    vt[1]  = '{8'h03, 8'h00, 8'h00, 1'b0, 1'b1, RB ? 8'hC4 : 8'h00, 0, 0};
    vt[2]  = '{8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 1, 0};
    vt[3]  = '{8'h80, 8'h03, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1};
    vt[4]  = '{8'h05, 8'h00, 8'h5A, 1'b0, 1'b1, 8'h5A, 0, 0};
    vt[5]  = '{8'h07, 8'h00, 8'h5A, 1'b0, 1'b1, 8'hA5, 0, 0};
    vt[6]  = '{8'h85, 8'hFF, 8'h5A, 1'b0, 1'b0, 8'h00, 0, 0};
    vt[7]  = '{8'h05, 8'h00, 8'h5A, 1'b0, 1'b1, 8'h5A, 0, 0};
    vt[8]  = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 0, 0};
    vt[9]  = '{8'h86, 8'h9C, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0};
    vt[10] = '{8'h06, 8'h00, 8'h00, 1'b0, 1'b1, RB ? 8'h9C : 8'h00, 0, 0};
    vt[11] = '{8'h78, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 0, 0};
    vt[12] = '{8'h80, 8'h02, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1};

    for (int a = 0; a < 8; a++) mdl[a] = 8'h00;
    rst = 1'b1; ena = 1'b1; spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    rsa_c = 8'h00; irq = 1'b0;
    repeat (3) @(negedge clk);
    chk_regs("reset");
    check("reset miso", spi_miso, 1'b0);
    check("reset start", start_cmd, 1'b0);
    check("reset stop", stop_cmd, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Write P with latency observation: old value 3 clks after the last edge, new value at 4.
    spi_xfer({8'h81, 8'h3D}, 16, 1'b0, rx);
    check("wrP lat3", snap3, 8'h00);
    check("wrP lat4", snap4, 8'h3D);
    model_write(3'd1, 8'h3D);
    chk_regs("wrP");

    for (int v = 0; v < 13; v++) begin
      rsa_c = vt[v].c_in;
      irq = vt[v].irq_in;
      s0 = start_seen; t0 = stop_seen;
      spi_xfer({vt[v].cmd, vt[v].data}, 16, 1'b0, rx);
      if (vt[v].is_rd) check($sformatf("vec%0d rd", v), rx, vt[v].exp_rd);
      check($sformatf("vec%0d start", v), start_seen - s0, vt[v].exp_start);
      check($sformatf("vec%0d stop", v), stop_seen - t0, vt[v].exp_stop);
      if (!vt[v].is_rd) model_write(vt[v].cmd[2:0], vt[v].data);
      chk_regs($sformatf("vec%0d", v));
    end
    irq = 1'b0;

    // Aborted frames: no write, no pulses; then a complete frame still works.
    s0 = start_seen; t0 = stop_seen;
    spi_xfer({8'h82, 8'h77}, 12, 1'b0, rx);
    check("abort rsa_e", rsa_e, 8'h00);
    spi_xfer({8'h80, 8'h03}, 12, 1'b0, rx);
    check("abort start", start_seen - s0, 0);
    check("abort stop", stop_seen - t0, 0);
    spi_xfer({8'h82, 8'h77}, 16, 1'b0, rx);
    check("after abort rsa_e", rsa_e, 8'h77);
    model_write(3'd2, 8'h77);
    chk_regs("after abort");

    // Reset in the middle of a read of ID (MISO carries bit5 of A5 = 1 at this point).
    spi_xfer({8'h07, 8'h00}, 10, 1'b1, rx);
    check("midframe miso", spi_miso, 1'b1);
    rst = 1'b1;
    spi_cs_n = 1'b1;
    #1;
    for (int a = 0; a < 8; a++) mdl[a] = 8'h00;
    chk_regs("rst");
    check("rst miso", spi_miso, 1'b0);
    check("rst start", start_cmd, 1'b0);
    check("rst stop", stop_cmd, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // With ena low frames are ignored and registers hold.
    spi_xfer({8'h81, 8'h3C}, 16, 1'b0, rx);
    model_write(3'd1, 8'h3C);
    ena = 1'b0;
    s0 = start_seen;
    spi_xfer({8'h81, 8'h11}, 16, 1'b0, rx);
    check("ena0 rsa_p", rsa_p, 8'h3C);
    spi_xfer({8'h80, 8'h01}, 16, 1'b0, rx);
    check("ena0 start", start_seen - s0, 0);
    ena = 1'b1;
    repeat (4) @(negedge clk);
    chk_regs("ena1");

    for (int n = 0; n < 40; n++) begin
      cmd = 8'($urandom);
      data = 8'($urandom);
      rsa_c = 8'($urandom);
      irq = 1'($urandom_range(0, 1));
      nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : 16;
      es = 0; et = 0;
      s0 = start_seen; t0 = stop_seen;
      spi_xfer({cmd, data}, nb, 1'b0, rx);
      if (nb == 16) begin
        if (cmd[7]) begin
          if (cmd[2:0] == 3'd0) begin
            et = data[1] ? 1 : 0;
            es = (data[0] && !data[1]) ? 1 : 0;
          end
          model_write(cmd[2:0], data);
        end else begin
          check($sformatf("rnd%0d rd a%0d", n, cmd[2:0]), rx, model_read(cmd[2:0]));
        end
      end
      check($sformatf("rnd%0d start", n), start_seen - s0, es);
      check($sformatf("rnd%0d stop", n), stop_seen - t0, et);
      chk_regs($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
